// File: rtl/digit_unloader.sv
// digit_unloader: holds up to eight hex digits written one at a time, then emits them
// oldest-first, one digit per CNT-cycle tick, and shows the held slots on 7-segment displays.
module digit_unloader #(
    parameter int CNT = 100000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] D,
    input  logic       WE,
    input  logic       START,
    output logic [3:0] Q,
    output logic       QV,
    output logic       BUSY,
    output logic       FULL,
    output logic [3:0] COUNT,
    output logic       LEDC,
    output logic [6:0] HEXq7,
    output logic [6:0] HEXq6,
    output logic [6:0] HEXq5,
    output logic [6:0] HEXq4,
    output logic [6:0] HEXq3,
    output logic [6:0] HEXq2,
    output logic [6:0] HEXq1,
    output logic [6:0] HEXq0
);
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam logic [26:0] LAST = 27'(CNT - 1);
    state_t state;
    logic [3:0] q [8];
    logic [26:0] tick;
    // active-low segments, bit order gfedcba
    function automatic logic [6:0] dec_7seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            for (int i = 0; i < 8; i++) q[i] <= 4'd0;
            COUNT <= 4'd0;
            Q <= 4'd0;
            QV <= 1'b0;
            LEDC <= 1'b0;
            tick <= 27'd0;
        end else begin
            QV <= 1'b0;
            if (state == IDLE) begin
                // START is judged on the pre-write count and wins over WE
                if (START && COUNT != 4'd0) begin
                    state <= SHIFT;
                    tick <= 27'd0;
                end else if (WE && COUNT < 4'd8) begin
                    q[COUNT[2:0]] <= D;
                    COUNT <= COUNT + 4'd1;
                end
            end else if (tick == LAST) begin
                tick <= 27'd0;
                Q <= q[0];
                QV <= 1'b1;
                for (int i = 0; i < 7; i++) q[i] <= q[i+1];
                q[7] <= 4'd0;
                COUNT <= COUNT - 4'd1;
                LEDC <= (COUNT == 4'd1) ? 1'b0 : ~LEDC;
                if (COUNT == 4'd1) state <= IDLE;
            end else begin
                tick <= tick + 27'd1;
            end
        end
    end
    assign BUSY  = (state == SHIFT);
    assign FULL  = (COUNT == 4'd8);
    assign HEXq0 = dec_7seg(q[0]);
    assign HEXq1 = dec_7seg(q[1]);
    assign HEXq2 = dec_7seg(q[2]);
    assign HEXq3 = dec_7seg(q[3]);
    assign HEXq4 = dec_7seg(q[4]);
    assign HEXq5 = dec_7seg(q[5]);
    assign HEXq6 = dec_7seg(q[6]);
    assign HEXq7 = dec_7seg(q[7]);
endmodule

// File: doc/digit_unloader.md
# digit_unloader

- Parallel-in, serial-out companion to the board's digit shift-in register.
- Holds up to eight 4-bit hex digits written one at a time, then on command emits them oldest-first, one digit per tick period, on a 4-bit output with a one-cycle valid strobe.
- The held digits drive eight 7-segment displays through the team's `dec_7seg` decoder.
- Sits between the DIP-switch/key front end and any downstream digit consumer on the 50 MHz FPGA board.

## Interface
Parameters:
- `CNT`, default 100000000: tick period in `CLK` cycles, 2 s at 50 MHz. Legal range is ≥ 2.
- Counter width is 27 bits, which is sufficient for the default value.

Ports:
- `CLK` in 1: the single clock, 50 MHz.
- `RST_N` in 1: asynchronous, active-low reset.
- `D` in 4: digit to write.
- `WE` in 1: write strobe, sampled every cycle.
- `START` in 1: begin unloading, sampled every cycle.
- `Q` in/out: out 4: last emitted digit.
- `QV` out 1: one-cycle pulse per emitted digit.
- `BUSY` out 1: high while unloading.
- `FULL` out 1: high when `COUNT`==8.
- `COUNT` out 4: number of digits held, 0..8.
- `LEDC` out 1: tick indicator.
- `HEXq7`..`HEXq0` out 7 each: `dec_7seg` encoding of buffer slots `q7`..`q0`.

## Operation
- **Storage:** slots `q0`..`q7`, 4 bits each. `q0` is the oldest digit. Unused slots hold 0.
- **States:** IDLE and SHIFT. `BUSY` = (state==SHIFT).
- **Reset:** asynchronous, and effective mid-operation. Sets:
  - all slots = 0
  - `COUNT` = 0
  - `Q` = 0
  - `QV` = 0
  - `LEDC` = 0
  - tick counter = 0
  - state = IDLE
- **IDLE, write:** `WE`=1 with `COUNT`<8 stores `D` into slot `q[COUNT]` and increments `COUNT`.
  - `WE` with `COUNT`==8 is ignored; no slot changes.
- **IDLE, start:** `START`=1 with `COUNT`>0 enters SHIFT and clears the tick counter.
  - `START` with `COUNT`==0 is ignored.
- **Simultaneous `WE`+`START` in IDLE:** `START` is judged against the pre-write `COUNT`.
  - If `START` is accepted, `WE` is dropped.
  - Otherwise `WE` is processed normally.
- **SHIFT:** the tick counter increments each cycle.
  - When counter==`CNT`-1, the block:
    - clears the counter
    - sets `Q`←`q0` and pulses `QV`
    - shifts `q0`←`q1`, …, `q6`←`q7`, `q7`←0
    - decrements `COUNT`
    - toggles `LEDC`
  - If the post-decrement `COUNT`==0, the state returns to IDLE and `LEDC` is forced to 0.
- **SHIFT, inputs ignored:** `WE` and `START` have no effect in SHIFT; buffer contents are not altered by writes.
- **`Q`:** holds its value between emissions and across return to IDLE.
- **Emission order:** digits are emitted in write order (FIFO).

## Timing
- All outputs are registered.
- `HEXq*` are combinational decodes of the registered slots.
- **Write:** `WE` sampled at edge n → slot, `COUNT` and `FULL` update after edge n. `HEXq*` reflects the new slot in the same cycle.
- **Start:** `START` accepted at edge t → `BUSY`=1 after t.
- **Emissions:** the k-th emission (k=1..N) occurs at edge t+k·`CNT`.
  - `QV`=1 for exactly the cycle following that edge.
  - `Q` and `COUNT` update at the same edge.
- **End of unload:** on the last emission, `BUSY` falls at the same edge that raises `QV`.
  - A new `WE`/`START` is accepted from the next edge.
- **Minimum spacing:** consecutive `QV` pulses are exactly `CNT` cycles apart, with no gap between a full unload's emissions.
- **Reset mid-SHIFT:** outputs clear immediately without waiting for `CLK`. No `QV` pulse is produced.

## Test plan
Use `CNT`=4 for simulation.
- **Basic unload:** after reset, write 1,2,3 (`WE` pulses), then `START`.
  - `QV` at +4, +8, +12 cycles with `Q`=1,2,3.
  - `COUNT` 3→2→1→0.
  - `BUSY` falls with the third `QV`.
  - `LEDC` ends at 0.
- **Full buffer:** write 0..7, then a ninth write of F.
  - `FULL`=1, `COUNT`=8, `q7`=7, F is discarded.
  - Unload emits 0..7 exactly.
- **Start on empty:** `START` with `COUNT`=0 → `BUSY` stays 0, no `QV`.
  - **Same-cycle `START`+`WE`, empty buffer:** `WE` of D=A is accepted, then a later `START` emits A.
- **Same-cycle `START`+`WE`, non-empty buffer:** with 2 digits held, assert both with D=9.
  - Only 2 digits are emitted; 9 is never stored.
  - **Write during SHIFT:** `WE` during SHIFT leaves the buffer unchanged.
- **Reset mid-unload:** assert `RST_N`=0 between the 1st and 2nd `QV`.
  - Asynchronously, all outputs go to 0, `COUNT`=0 and `BUSY`=0.
  - No further `QV`.
- **Display:** after writing 5 and C, `HEXq0`=`dec_7seg`(5), `HEXq1`=`dec_7seg`(C), all others `dec_7seg`(0).
  - After one emission, `HEXq0`=`dec_7seg`(C).
